adsr_voice_scheduler: RTL
=========================

# adsr_voice_scheduler

Multi-voice envelope controller that shares a single ADSR gain multiplier among `NUM_VOICES` sample requesters. It keeps a per-voice attack/decay/sustain/release state machine and level register, and arbitrates requesters round-robin onto one multiplier. It emits one enveloped sample per cycle, tagged with its voice index. It sits between the per-voice oscillators and the mixer, replacing one envelope instance per voice.

## Interface
- `NUM_VOICES`, default 4: number of voices; power of two, 2..8.
- `ATTACK_STEP`, default 16'd512: level increment per accepted sample in ATTACK.
- `DECAY_STEP`, default 16'd64: level decrement per accepted sample in DECAY.
- `SUSTAIN_LEVEL`, default 16'd16384: DECAY floor and SUSTAIN hold level.
- `RELEASE_STEP`, default 16'd32: level decrement per accepted sample in RELEASE.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `note_on` in NUM_VOICES: one-cycle pulse per voice that starts or retriggers the envelope.
- `note_off` in NUM_VOICES: one-cycle pulse per voice that enters release.
- `in_ready` in NUM_VOICES: per-voice sample request. It is held until acknowledged.
- `sample_in` in 16*NUM_VOICES: signed sample; voice v occupies bits [16v+15:16v].
- `in_ack` out NUM_VOICES: one-hot grant pulse. The sample is consumed on this cycle.
- `sample_out` out 16: signed enveloped sample.
- `out_valid` out 1: `sample_out` and `out_voice` are valid this cycle.
- `out_voice` out log2(NUM_VOICES): index of the voice carried by `sample_out`.
- `voice_active` out NUM_VOICES: a bit is 1 when that voice's state is not IDLE.

## Operation
- **Per-voice state:** IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, plus a 16-bit unsigned `level`. `level` ranges over 0..32767 and is read as Q1.15 gain.
- **Note events:** applied at the clock edge, independent of grants.
  - `note_on`: any state -> ATTACK. `level` is kept, so a retrigger produces no click.
  - `note_off`: ATTACK/DECAY/SUSTAIN -> RELEASE. It is ignored in IDLE and RELEASE.
  - `note_on` and `note_off` in the same cycle: `note_on` wins.
  - A note event in the same cycle as a grant to that voice suppresses that voice's envelope step for that cycle.
- **Arbiter:** round-robin over voices with `in_ready`=1. The search starts at last granted + 1, modulo NUM_VOICES. Exactly one grant per cycle when any request is present. Grants are made regardless of state, so IDLE voices are granted too and yield 0.
- **Envelope step:** on grant, using saturating arithmetic in a 17-bit intermediate.
  - ATTACK: `level` += ATTACK_STEP, clamped to 32767. On reaching 32767 -> DECAY.
  - DECAY: `level` -= DECAY_STEP, clamped to SUSTAIN_LEVEL. On reaching it -> SUSTAIN.
  - SUSTAIN: `level` unchanged.
  - RELEASE: `level` -= RELEASE_STEP, clamped to 0. On reaching 0 -> IDLE.
  - IDLE: `level` stays 0.
- **Multiply:** the product uses the pre-step `level`. Compute `sample_in` (signed 16) × {1'b0, `level`} (signed 17), giving a 33-bit product. Arithmetic-shift right by 15 and keep the low 16 bits. No overflow is possible: -32768 × 32767 >>> 15 = -32767.

## Timing
- **Reset values:** all states IDLE, all `level` = 0, round-robin pointer so that voice 0 has first priority. `in_ack`=0, `out_valid`=0, `sample_out`=0, `out_voice`=0, `voice_active`=0.
- **`in_ack`:** combinational from `in_ready` and the registered pointer. It is asserted in the same cycle the request is seen.
- **Requester rule:** hold `sample_in` stable while `in_ready`=1 and `in_ack`=0. Deassert or present the next sample after the ack cycle.
- **Latency:** `sample_out`/`out_valid`/`out_voice` are registered and appear 1 cycle after `in_ack`.
- **Throughput:** one sample per cycle, no bubbles.
- **`voice_active`:** registered; it reflects the state after the edge.
- **Reset mid-operation:** all outputs go to reset values immediately (asynchronous). No pending grant survives.

## Structure
- **Shared package `synth_pkg`:** the envelope state enum, `LEVEL_MAX` = 32767, and `SAMPLE_W` = 16.
- **Sub-module `adsr_env_state`:** one instance per voice. It holds state and `level`, and takes note pulses plus a step enable.
- **Top level:** contains the round-robin arbiter, the sample mux, the shared multiplier and the output register.

## Test plan
- **Reset and idle grant:** reset low, then `in_ready`=4'b0001 with `sample_in[0]`=32767. Expect `in_ack`=0001, and `sample_out`=0 with `out_voice`=0 one cycle later. `voice_active`=0.
- **Attack and decay:** ATTACK_STEP=8192 and `note_on[1]`, then voice 1 requests continuously with sample 32767. Expect gains 0, 8192, 16384, 24576, 32767 and outputs 0, 8191, 16383, 24575, 32766. Then DECAY steps down to SUSTAIN_LEVEL, after which the output holds at 16383.
- **Round-robin:** all four `in_ready`=1 constantly. Expect the `in_ack` sequence 0001, 0010, 0100, 1000, 0001, with `out_voice` 0, 1, 2, 3, 0 lagging by one cycle.
- **Release to idle:** `note_off[2]` in SUSTAIN with `level`=16384 and RELEASE_STEP=8192. Expect two grants at gains 16384 and 8192, after which the voice reaches 0. Expect `voice_active[2]` to fall and later outputs to be 0.
- **Simultaneous events:** `note_on[3]` and `note_off[3]` in the same cycle as a grant to voice 3 in SUSTAIN. Expect state ATTACK, `level` unchanged that cycle, and the output computed with the old level.
- **Negative full-scale:** `level`=32767 with sample -32768 gives output -32767. Asserting reset during continuous traffic clears `out_valid` within the same cycle.

Source files
------------

// File: rtl/adsr_voice_scheduler_pkg.sv
// Shared definitions for the ADSR voice scheduler: envelope states and sample/level limits.
package synth_pkg;

    localparam int          SAMPLE_W  = 16;
    localparam logic [15:0] LEVEL_MAX = 16'd32767;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

endpackage

// File: rtl/adsr_voice_scheduler_if.sv
// Voice-side bundle: note pulses, sample request/ack handshake and the enveloped output stream.
interface adsr_voice_scheduler_if #(
    parameter int NUM_VOICES = 4
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [NUM_VOICES-1:0]    note_on;
    logic [NUM_VOICES-1:0]    note_off;
    logic [NUM_VOICES-1:0]    in_ready;
    logic [16*NUM_VOICES-1:0] sample_in;
    logic [NUM_VOICES-1:0]    in_ack;
    logic [15:0]              sample_out;
    logic                     out_valid;
    logic [VW-1:0]            out_voice;
    logic [NUM_VOICES-1:0]    voice_active;

    modport master (
        output note_on, note_off, in_ready, sample_in,
        input  in_ack, sample_out, out_valid, out_voice, voice_active
    );

    modport slave (
        input  note_on, note_off, in_ready, sample_in,
        output in_ack, sample_out, out_valid, out_voice, voice_active
    );

endinterface

// File: rtl/adsr_env_state.sv
// Per-voice ADSR envelope: state and Q1.15 level, stepped once per granted sample.
//
//   state       | meaning
//   ENV_IDLE    | silent, level held at 0
//   ENV_ATTACK  | level rises by ATTACK_STEP per grant up to LEVEL_MAX
//   ENV_DECAY   | level falls by DECAY_STEP per grant down to SUSTAIN_LEVEL
//   ENV_SUSTAIN | level held at SUSTAIN_LEVEL
//   ENV_RELEASE | level falls by RELEASE_STEP per grant down to 0, then idle
module adsr_env_state
    import synth_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP   = 16'd512,
    parameter logic [15:0] DECAY_STEP    = 16'd64,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'd16384,
    parameter logic [15:0] RELEASE_STEP  = 16'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_on,
    input  logic        note_off,
    input  logic        step_en,
    output logic [15:0] level,
    output logic        active
);

    env_state_t  state;
    logic [16:0] atk_sum;
    logic [16:0] dec_floor;

    assign atk_sum   = {1'b0, level} + {1'b0, ATTACK_STEP};
    assign dec_floor = {1'b0, SUSTAIN_LEVEL} + {1'b0, DECAY_STEP};

    // Note pulses take priority and swallow any step in the same cycle; retrigger keeps level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ENV_IDLE;
            level  <= '0;
            active <= 1'b0;
        end else if (note_on) begin
            state  <= ENV_ATTACK;
            active <= 1'b1;
        end else if (note_off) begin
            if (state inside {ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN}) begin
                state <= ENV_RELEASE;
            end
        end else if (step_en) begin
            case (state)
                ENV_ATTACK: begin
                    if (atk_sum >= {1'b0, LEVEL_MAX}) begin
                        level <= LEVEL_MAX;
                        state <= ENV_DECAY;
                    end else begin
                        level <= atk_sum[15:0];
                    end
                end
                ENV_DECAY: begin
                    if ({1'b0, level} <= dec_floor) begin
                        level <= SUSTAIN_LEVEL;
                        state <= ENV_SUSTAIN;
                    end else begin
                        level <= level - DECAY_STEP;
                    end
                end
                ENV_RELEASE: begin
                    if (level <= RELEASE_STEP) begin
                        level  <= '0;
                        state  <= ENV_IDLE;
                        active <= 1'b0;
                    end else begin
                        level <= level - RELEASE_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/adsr_voice_scheduler.sv
// Shares one envelope gain multiplier across all voices with a round-robin sample arbiter.
module adsr_voice_scheduler
    import synth_pkg::*;
#(
    parameter int          NUM_VOICES    = 4,
    parameter logic [15:0] ATTACK_STEP   = 16'd512,
    parameter logic [15:0] DECAY_STEP    = 16'd64,
    parameter logic [15:0] SUSTAIN_LEVEL = 16'd16384,
    parameter logic [15:0] RELEASE_STEP  = 16'd32
) (
    input  logic                 clk,
    input  logic                 reset,
    adsr_voice_scheduler_if.slave bus
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [VW-1:0]               last_grant;
    logic [VW-1:0]               search_idx;
    logic [VW-1:0]               grant_idx;
    logic                        grant_any;
    logic [NUM_VOICES-1:0]       grant;
    logic [15:0]                 level_arr [NUM_VOICES];
    logic signed [SAMPLE_W-1:0]  smp_arr   [NUM_VOICES];
    logic [NUM_VOICES-1:0]       active;
    logic signed [SAMPLE_W-1:0]  sample_sel;
    logic signed [30:0]          sample_ext;
    logic signed [30:0]          gain_ext;
    logic signed [30:0]          product;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        assign smp_arr[v] = bus.sample_in[v*SAMPLE_W +: SAMPLE_W];

        adsr_env_state #(
            .ATTACK_STEP   (ATTACK_STEP),
            .DECAY_STEP    (DECAY_STEP),
            .SUSTAIN_LEVEL (SUSTAIN_LEVEL),
            .RELEASE_STEP  (RELEASE_STEP)
        ) u_env (
            .clk      (clk),
            .reset    (reset),
            .note_on  (bus.note_on[v]),
            .note_off (bus.note_off[v]),
            .step_en  (grant[v]),
            .level    (level_arr[v]),
            .active   (active[v])
        );
    end

    // Round-robin search starting one past the last granted voice
    always_comb begin
        grant_any  = 1'b0;
        grant_idx  = '0;
        search_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            search_idx = last_grant + VW'(i + 1);
            if (!grant_any && bus.in_ready[search_idx]) begin
                grant_any = 1'b1;
                grant_idx = search_idx;
            end
        end
    end

    // Grant is masked while reset is held so no ack escapes during reset
    assign grant      = (grant_any && reset) ? (NUM_VOICES'(1) << grant_idx) : '0;
    assign bus.in_ack = grant;

    // Product uses the pre-step level; Q1.15 gain keeps the result inside 16 bits
    assign sample_sel = smp_arr[grant_idx];
    assign sample_ext = {{15{sample_sel[SAMPLE_W-1]}}, sample_sel};
    assign gain_ext   = {15'd0, level_arr[grant_idx]};
    assign product    = sample_ext * gain_ext;

    assign bus.voice_active = active;

    // Output register and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant     <= VW'(NUM_VOICES - 1);
            bus.out_valid  <= 1'b0;
            bus.sample_out <= '0;
            bus.out_voice  <= '0;
        end else begin
            bus.out_valid <= grant_any;
            if (grant_any) begin
                bus.sample_out <= 16'(product >>> 15);
                bus.out_voice  <= grant_idx;
                last_grant     <= grant_idx;
            end
        end
    end

endmodule
